systolic_array_stream: RTL and testbench

//  Parametrised driver for mac_array. Generalises the 2x2 driver to any HxW array.

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/mac_array.sv | 81 ++++++++
 rtl/onehot_counter.sv | 20 ++
 rtl/systolic_array_stream_result_drain.sv | 50 +++++
 rtl/systolic_array_stream.sv | 160 ++++++++++++++++
 tb/tb_systolic_array_stream.sv | 278 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array stream driver slice.
package systolic_pkg;

  // Driver FSM states, one-hot encoded.
  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    LOAD    = 5'b00010,
    COMPUTE = 5'b00100,
    DRAIN   = 5'b01000,
    CLEAR   = 5'b10000
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Step word order: row words occupy selector slots [0, H), column words follow.
  localparam int unsigned row_slot_base_lp = 0;

  function automatic int unsigned col_slot(input int unsigned h, input int unsigned j);
    return h + j;
  endfunction

endpackage

// File: rtl/mac_array.sv
// Operand-broadcast MAC grid: one operand buffer per row and per column; once every
// buffer holds a word, each cell accumulates a[i]*b[j] (modulo 2^width_p) and the
// buffers free up for the next step.
module mac_array #(
  parameter int unsigned width_p        = 32,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2
) (
  input  logic                                              clk_i,
  input  logic                                              reset_ni,
  input  logic                                              clear_i,
  input  logic                                              en_i,
  input  logic [array_height_p-1:0]                         row_v_i,
  output logic [array_height_p-1:0]                         row_ready_o,
  input  logic [width_p-1:0]                                row_data_i,
  input  logic [array_width_p-1:0]                          col_v_i,
  output logic [array_width_p-1:0]                          col_ready_o,
  input  logic [width_p-1:0]                                col_data_i,
  output logic [array_height_p*array_width_p*width_p-1:0]   z_o
);

  localparam int unsigned els_lp = array_height_p * array_width_p;

  logic [width_p-1:0]        a_r   [array_height_p];
  logic [width_p-1:0]        b_r   [array_width_p];
  logic [width_p-1:0]        acc_r [els_lp];
  logic [array_height_p-1:0] a_full_r;
  logic [array_width_p-1:0]  b_full_r;
  logic                      fire;

  assign fire        = (&a_full_r) & (&b_full_r);
  assign row_ready_o = ~a_full_r;
  assign col_ready_o = ~b_full_r;

  // Operand capture, then one accumulate cycle once all operands are present.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      a_full_r <= '0;
      b_full_r <= '0;
      for (int unsigned i = 0; i < array_height_p; i++) a_r[i] <= '0;
      for (int unsigned j = 0; j < array_width_p; j++) b_r[j] <= '0;
      for (int unsigned k = 0; k < els_lp; k++) acc_r[k] <= '0;
    end else if (clear_i) begin
      a_full_r <= '0;
      b_full_r <= '0;
      for (int unsigned k = 0; k < els_lp; k++) acc_r[k] <= '0;
    end else if (en_i) begin
      if (fire) begin
        a_full_r <= '0;
        b_full_r <= '0;
        for (int unsigned i = 0; i < array_height_p; i++) begin
          for (int unsigned j = 0; j < array_width_p; j++) begin
            acc_r[i*array_width_p + j] <= acc_r[i*array_width_p + j] + a_r[i] * b_r[j];
          end
        end
      end else begin
        for (int unsigned i = 0; i < array_height_p; i++) begin
          if (row_v_i[i] && !a_full_r[i]) begin
            a_r[i]      <= row_data_i;
            a_full_r[i] <= 1'b1;
          end
        end
        for (int unsigned j = 0; j < array_width_p; j++) begin
          if (col_v_i[j] && !b_full_r[j]) begin
            b_r[j]      <= col_data_i;
            b_full_r[j] <= 1'b1;
          end
        end
      end
    end
  end

  // Pack accumulators row-major: slice k holds C[k/W][k%W].
  always_comb begin
    z_o = '0;
    for (int unsigned k = 0; k < els_lp; k++) begin
      z_o[k*width_p +: width_p] = acc_r[k];
    end
  end

endmodule

// File: rtl/onehot_counter.sv
// Rotating one-hot selector; advances one position per enabled cycle and wraps.
module onehot_counter #(
  parameter int unsigned width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               en_i,
  output logic [width_p-1:0] onehot_o
);

  // Rotate left on advance; bit 0 after reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      onehot_o <= width_p'(1);
    end else if (en_i) begin
      onehot_o <= (onehot_o << 1) | (onehot_o >> (width_p - 1));
    end
  end

endmodule

// File: rtl/systolic_array_stream_result_drain.sv
// Result drain: row-major index counter, H*W:1 output mux and valid/yumi handshake.
module result_drain
  import systolic_pkg::*;
#(
  parameter int unsigned width_p = 32,
  parameter int unsigned els_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         en_i,
  input  logic                         start_i,
  input  logic                         yumi_i,
  input  logic [els_p*width_p-1:0]     z_i,
  output logic                         valid_o,
  output logic                         done_o,
  output logic [width_p-1:0]           data_o,
  output logic [idx_width(els_p)-1:0]  idx_o
);

  localparam int unsigned iw_lp = idx_width(els_p);
  localparam logic [iw_lp-1:0] last_lp = iw_lp'(els_p - 1);

  logic active_r;
  logic last;

  assign last    = (idx_o == last_lp);
  assign valid_o = active_r;
  assign done_o  = en_i & active_r & yumi_i & last;
  assign data_o  = z_i[idx_o*width_p +: width_p];

  // Hold the current result until it is taken; wrap the index after the last one.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      active_r <= 1'b0;
      idx_o    <= '0;
    end else if (en_i) begin
      if (start_i) begin
        active_r <= 1'b1;
      end else if (active_r && yumi_i) begin
        if (last) begin
          idx_o    <= '0;
          active_r <= 1'b0;
        end else begin
          idx_o <= idx_o + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/systolic_array_stream.sv
// Stream driver for an HxW mac_array: serialises operand words into row/column
// consumers, drains results row-major over valid/yumi, then clears the array.
// Optional: SYSTOLIC_ARRAY_STREAM_AUTO_FLUSH_EN drains automatically after depth_p steps.
module systolic_array_stream
  import systolic_pkg::*;
#(
  parameter int unsigned width_p        = 32,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2,
  parameter int unsigned depth_p        = 2
) (
  input  logic                                                clk_i,
  input  logic                                                reset_ni,
  input  logic                                                en_i,
  input  logic                                                flush_i,
  input  logic                                                valid_i,
  output logic                                                ready_o,
  input  logic [width_p-1:0]                                  data_i,
  output logic                                                valid_o,
  input  logic                                                yumi_i,
  output logic [width_p-1:0]                                  data_o,
  output logic [idx_width(array_height_p*array_width_p)-1:0]  idx_o,
  output logic                                                busy_o
);

  localparam int unsigned h_lp     = array_height_p;
  localparam int unsigned w_lp     = array_width_p;
  localparam int unsigned slots_lp = h_lp + w_lp;
  localparam int unsigned els_lp   = h_lp * w_lp;
  localparam int unsigned step_w_lp = idx_width(depth_p + 1);
  localparam int unsigned col_base_lp = col_slot(h_lp, 0);

  state_e                 state_r;
  logic                   flush_pending_r;
  logic [step_w_lp-1:0]   step_cnt_r;

  logic [slots_lp-1:0]    sel;
  logic [slots_lp-1:0]    cons_ready;
  logic [slots_lp-1:0]    cons_valid;
  logic [h_lp-1:0]        row_ready;
  logic [w_lp-1:0]        col_ready;
  logic [els_lp*width_p-1:0] z;

  logic in_idle, in_load, in_compute, in_clear;
  logic flush_req, gate, accept, last_word, all_ready, auto_hit;
  logic drain_go, drain_done, drain_valid;

  assign in_idle    = (state_r == IDLE);
  assign in_load    = (state_r == LOAD);
  assign in_compute = (state_r == COMPUTE);
  assign in_clear   = (state_r == CLEAR);

  assign cons_ready = {col_ready, row_ready};
  assign flush_req  = flush_i | flush_pending_r;
  // A flush seen in IDLE wins over an offered word.
  assign gate       = en_i & (in_idle | in_load) & ~(in_idle & flush_req);
  assign ready_o    = gate & |(sel & cons_ready);
  assign accept     = valid_i & ready_o;
  assign last_word  = sel[slots_lp-1];
  assign all_ready  = &cons_ready;
  assign cons_valid = sel & {slots_lp{valid_i & gate}};

`ifdef SYSTOLIC_ARRAY_STREAM_AUTO_FLUSH_EN
  assign auto_hit = (step_cnt_r == step_w_lp'(depth_p));
`else
  assign auto_hit = 1'b0;
`endif

  assign drain_go = en_i & ((in_idle & flush_req) | (in_compute & all_ready & auto_hit));
  assign valid_o  = en_i & drain_valid;
  assign busy_o   = in_compute;

  onehot_counter #(.width_p(slots_lp)) u_sel (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (accept),
    .onehot_o (sel)
  );

  // The array's reset is split into the async system reset and a synchronous
  // clear during CLEAR; together they behave as ~reset_ni | (state==CLEAR).
  mac_array #(
    .width_p        (width_p),
    .array_width_p  (w_lp),
    .array_height_p (h_lp)
  ) u_mac (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .clear_i     (in_clear),
    .en_i        (en_i),
    .row_v_i     (cons_valid[row_slot_base_lp +: h_lp]),
    .row_ready_o (row_ready),
    .row_data_i  (data_i),
    .col_v_i     (cons_valid[col_base_lp +: w_lp]),
    .col_ready_o (col_ready),
    .col_data_i  (data_i),
    .z_o         (z)
  );

  result_drain #(
    .width_p (width_p),
    .els_p   (els_lp)
  ) u_drain (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (en_i),
    .start_i  (drain_go),
    .yumi_i   (yumi_i & valid_o),
    .z_i      (z),
    .valid_o  (drain_valid),
    .done_o   (drain_done),
    .data_o   (data_o),
    .idx_o    (idx_o)
  );

  // Control FSM with pending-flush and step bookkeeping; everything holds when en_i=0.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r         <= IDLE;
      flush_pending_r <= 1'b0;
      step_cnt_r      <= '0;
    end else if (en_i) begin
      case (state_r)
        IDLE: begin
          if (flush_req) begin
            state_r         <= DRAIN;
            flush_pending_r <= 1'b0;
          end else if (accept) begin
            state_r <= LOAD;
          end
        end
        LOAD: begin
          if (flush_i) flush_pending_r <= 1'b1;
          if (accept && last_word) begin
            state_r <= COMPUTE;
            if (step_cnt_r != '1) step_cnt_r <= step_cnt_r + 1'b1;
          end
        end
        COMPUTE: begin
          if (drain_go) begin
            state_r         <= DRAIN;
            flush_pending_r <= 1'b0;
          end else begin
            if (flush_i) flush_pending_r <= 1'b1;
            if (all_ready) state_r <= IDLE;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_r    <= CLEAR;
            step_cnt_r <= '0;
          end
        end
        CLEAR:   state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_stream.sv
// Directed bench for systolic_array_stream: 2x2 scenarios plus a 3x2 single-step case.
module tb_systolic_array_stream;

`ifdef SYSTOLIC_ARRAY_STREAM_AUTO_FLUSH_EN
  localparam int unsigned depth2_lp = 100;
`else
  localparam int unsigned depth2_lp = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 2x2 instance
  logic        en, flush, valid, yumi;
  logic [31:0] data;
  logic        rdy, vo, busy;
  logic [31:0] dout;
  logic [1:0]  idx;

  // 3x2 instance
  logic        en3, flush3, valid3, yumi3;
  logic [31:0] data3;
  logic        rdy3, vo3, busy3;
  logic [31:0] dout3;
  logic [2:0]  idx3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  systolic_array_stream #(
    .width_p(32), .array_width_p(2), .array_height_p(2), .depth_p(depth2_lp)
  ) u_dut (
    .clk_i(clk), .reset_ni(rst_n), .en_i(en), .flush_i(flush),
    .valid_i(valid), .ready_o(rdy), .data_i(data),
    .valid_o(vo), .yumi_i(yumi), .data_o(dout), .idx_o(idx), .busy_o(busy)
  );

  systolic_array_stream #(
    .width_p(32), .array_width_p(2), .array_height_p(3), .depth_p(1)
  ) u_dut3 (
    .clk_i(clk), .reset_ni(rst_n), .en_i(en3), .flush_i(flush3),
    .valid_i(valid3), .ready_o(rdy3), .data_i(data3),
    .valid_o(vo3), .yumi_i(yumi3), .data_o(dout3), .idx_o(idx3), .busy_o(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int unsigned n = 0;
    valid = 1'b1;
    data  = w;
    #1;
    while (!rdy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("send_wait", 32'(n < 50), 1);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic send_step(input logic [31:0] a0, a1, b0, b1);
    send_word(a0);
    send_word(a1);
    send_word(b0);
    send_word(b1);
    chk("busy_after_step", 32'(busy), 1);
  endtask

  task automatic wait_rdy();
    int unsigned n = 0;
    while (!rdy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("rdy_wait", 32'(rdy), 1);
  endtask

  task automatic flush_idle();
    wait_rdy();
    flush = 1'b1;
    #1;
    chk("flush_blocks_rdy", 32'(rdy), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("drain_latency", 32'(vo), 1);
  endtask

  task automatic drain4(input logic [31:0] e0, e1, e2, e3, input int unsigned hold_at);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = 0; k < 4; k++) begin
      int unsigned n = 0;
      while (!vo && n < 50) begin
        @(posedge clk); #1; n++;
      end
      chk("drain_valid", 32'(vo), 1);
      chk("drain_data", dout, e[k]);
      chk("drain_idx", 32'(idx), 32'(k));
      if (k == int'(hold_at)) begin
        repeat (5) begin
          @(posedge clk); #1;
          chk("hold_valid", 32'(vo), 1);
          chk("hold_data", dout, e[k]);
          chk("hold_idx", 32'(idx), 32'(k));
        end
      end
      yumi = 1'b1;
      @(posedge clk); #1;
      yumi = 1'b0;
    end
    chk("clear_valid", 32'(vo), 0);
    chk("clear_rdy", 32'(rdy), 0);
    @(posedge clk); #1;
    chk("post_clear_rdy", 32'(rdy), 1);
    chk("post_clear_data", dout, 0);
    chk("post_clear_idx", 32'(idx), 0);
  endtask

  task automatic send_word3(input logic [31:0] w);
    int unsigned n = 0;
    valid3 = 1'b1;
    data3  = w;
    #1;
    while (!rdy3 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("send3_wait", 32'(n < 50), 1);
    @(posedge clk); #1;
    valid3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp3 [6];
    int unsigned n;
    exp3[0] = 4; exp3[1] = 5; exp3[2] = 8; exp3[3] = 10; exp3[4] = 12; exp3[5] = 15;

    rst_n = 1'b0;
    en = 1'b1; flush = 1'b0; valid = 1'b0; yumi = 1'b0; data = '0;
    en3 = 1'b1; flush3 = 1'b0; valid3 = 1'b0; yumi3 = 1'b0; data3 = '0;

    // Reset values
    #12;
    chk("rst_valid", 32'(vo), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_data", dout, 0);
    #11;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", 32'(rdy), 1);

    // Basic 2x2 product with backpressure at idx 2
    send_step(1, 3, 5, 6);
    send_step(2, 4, 7, 8);
    flush_idle();
    drain4(19, 22, 43, 50, 2);

    // Flush pulsed mid-LOAD after word 2 of the step
    send_word(1);
    send_word(3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    send_word(5);
    send_word(6);
    chk("mid_flush_busy", 32'(busy), 1);
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("mid_flush_idle_rdy", 32'(rdy), 0);
    chk("mid_flush_idle_vo", 32'(vo), 0);
    @(posedge clk); #1;
    chk("mid_flush_drain", 32'(vo), 1);
    drain4(5, 6, 15, 18, 4);

    // Flush and valid together in IDLE: no word consumed
    valid = 1'b1; data = 99; flush = 1'b1;
    #1;
    chk("flush_valid_rdy", 32'(rdy), 0);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    chk("flush_valid_drain", 32'(vo), 1);
    drain4(0, 0, 0, 0, 4);
    send_step(1, 3, 5, 6);
    flush_idle();
    drain4(5, 6, 15, 18, 4);

    // Reset mid-DRAIN at idx 1, then rerun
    send_step(1, 3, 5, 6);
    send_step(2, 4, 7, 8);
    flush_idle();
    chk("pre_rst_data", dout, 19);
    yumi = 1'b1;
    @(posedge clk); #1;
    yumi = 1'b0;
    chk("pre_rst_idx", 32'(idx), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(vo), 0);
    chk("mid_rst_idx", 32'(idx), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_step(1, 3, 5, 6);
    send_step(2, 4, 7, 8);
    flush_idle();
    drain4(19, 22, 43, 50, 4);

    // en_i low for 3 cycles mid-LOAD
    send_word(1);
    send_word(3);
    valid = 1'b1; data = 5; en = 1'b0;
    repeat (3) begin
      #1;
      chk("en_low_rdy", 32'(rdy), 0);
      chk("en_low_busy", 32'(busy), 0);
      @(posedge clk);
    end
    #1;
    en = 1'b1;
    #1;
    chk("en_resume_rdy", 32'(rdy), 1);
    send_word(5);
    send_word(6);
    chk("en_step_busy", 32'(busy), 1);
    send_step(2, 4, 7, 8);
    flush_idle();
    drain4(19, 22, 43, 50, 4);

    // 3x2, single step of 5 words
    send_word3(1);
    send_word3(2);
    send_word3(3);
    send_word3(4);
    send_word3(5);
    chk("busy3", 32'(busy3), 1);
`ifndef SYSTOLIC_ARRAY_STREAM_AUTO_FLUSH_EN
    n = 0;
    while (!rdy3 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("rdy3_wait", 32'(rdy3), 1);
    flush3 = 1'b1;
    @(posedge clk); #1;
    flush3 = 1'b0;
`endif
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!vo3 && n < 50) begin
        @(posedge clk); #1; n++;
      end
      chk("drain3_valid", 32'(vo3), 1);
      chk("drain3_data", dout3, exp3[k]);
      chk("drain3_idx", 32'(idx3), 32'(k));
      yumi3 = 1'b1;
      @(posedge clk); #1;
      yumi3 = 1'b0;
    end
    chk("drain3_end_valid", 32'(vo3), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
